// File: rtl/ddr3_user_port_arbiter_if.sv
// Bundle of the arbiter's request, response and controller-side signals.
//
// Request handshake: a request transfers on the rising clk edge where
// pN_req_valid && pN_req_ready are both high. Ready is offered only in IDLE,
// only to the granted port, and only while that port is valid. A requester
// holds write/addr/wdata stable while valid is high and no transfer has
// happened yet. Responses are one-cycle rsp_valid pulses and cannot be stalled.
interface ddr3_user_port_arbiter_if #(
   parameter int ADDR_W       = 17,
   parameter int DQ_W         = 16,
   parameter int STATE_W      = 5,
   parameter int MAX_POSTPONE = 8
);
   localparam int EC_W = $clog2(MAX_POSTPONE) + 1;

   logic              p0_req_valid;
   logic              p0_req_ready;
   logic              p0_req_write;
   logic [ADDR_W-1:0] p0_req_addr;
   logic [DQ_W-1:0]   p0_req_wdata;

   logic              p1_req_valid;
   logic              p1_req_ready;
   logic              p1_req_write;
   logic [ADDR_W-1:0] p1_req_addr;
   logic [DQ_W-1:0]   p1_req_wdata;

   logic              rsp_valid;
   logic              rsp_port;
   logic [DQ_W-1:0]   rsp_rdata;
   logic              rsp_error;

   logic              ctrl_write_enable;
   logic              ctrl_read_enable;
   logic [ADDR_W-1:0] ctrl_address;
   logic [DQ_W-1:0]   ctrl_wdata;
   logic [STATE_W-1:0] ctrl_main_state;
   logic [DQ_W-1:0]   ctrl_rdata;
   logic              ctrl_rdata_valid;
   logic [EC_W-1:0]   ctrl_extra_cycles;

   logic              busy;
   logic [1:0]        dbg_state;

   // Arbiter side.
   modport slave (
      input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
      input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
      output p0_req_ready, p1_req_ready,
      output rsp_valid, rsp_port, rsp_rdata, rsp_error,
      output ctrl_write_enable, ctrl_read_enable, ctrl_address, ctrl_wdata,
      input  ctrl_main_state, ctrl_rdata, ctrl_rdata_valid,
      output ctrl_extra_cycles, busy, dbg_state
   );

   // Requester / controller side.
   modport master (
      output p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata,
      output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata,
      input  p0_req_ready, p1_req_ready,
      input  rsp_valid, rsp_port, rsp_rdata, rsp_error,
      input  ctrl_write_enable, ctrl_read_enable, ctrl_address, ctrl_wdata,
      output ctrl_main_state, ctrl_rdata, ctrl_rdata_valid,
      input  ctrl_extra_cycles, busy, dbg_state
   );
endinterface

// File: rtl/ddr3_user_port_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller user port between two
// requesters, one transaction in flight. The command is held until the
// controller's main_state shows it was consumed; reads then wait for data
// (or time out) and return a single response pulse tagged with the port.
module ddr3_user_port_arbiter #(
   parameter int ADDR_W           = 17,
   parameter int DQ_W             = 16,
   parameter int STATE_W          = 5,
   parameter int STATE_WRITE_DATA = 8,
   parameter int STATE_READ_DATA  = 11,
   parameter int MAX_POSTPONE     = 8,
   parameter int READ_TIMEOUT     = 1023
) (
   input logic                     clk,
   input logic                     reset,
   ddr3_user_port_arbiter_if.slave bus
);
   localparam int EC_W  = $clog2(MAX_POSTPONE) + 1;
   localparam int TMR_W = $clog2(READ_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_n;
   logic              last_grant;
   logic              grant;
   logic              take;
   logic              accept;
   logic              rd_hit;
   logic              rd_timeout;
   logic              lat_write;
   logic              lat_port;
   logic [TMR_W-1:0]  timer;

   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DQ_W-1:0]   sel_wdata;

   logic              write_enable;
   logic              read_enable;
   logic [ADDR_W-1:0] address;
   logic [DQ_W-1:0]   wdata;
   logic              rsp_valid;
   logic              rsp_port;
   logic [DQ_W-1:0]   rsp_rdata;
   logic              rsp_error;
   logic [EC_W-1:0]   extra_cycles;
   logic [EC_W-1:0]   extra_n;
   logic [2:0]        demand;

   // Request fields of whichever port currently holds the grant.
   assign sel_write = grant ? bus.p1_req_write : bus.p0_req_write;
   assign sel_addr  = grant ? bus.p1_req_addr  : bus.p0_req_addr;
   assign sel_wdata = grant ? bus.p1_req_wdata : bus.p0_req_wdata;

   assign bus.p0_req_ready = ~reset & (state == IDLE) & ~grant & bus.p0_req_valid;
   assign bus.p1_req_ready = ~reset & (state == IDLE) &  grant & bus.p1_req_valid;

   assign bus.ctrl_write_enable = write_enable;
   assign bus.ctrl_read_enable  = read_enable;
   assign bus.ctrl_address      = address;
   assign bus.ctrl_wdata        = wdata;
   assign bus.rsp_valid         = rsp_valid;
   assign bus.rsp_port          = rsp_port;
   assign bus.rsp_rdata         = rsp_rdata;
   assign bus.rsp_error         = rsp_error;
   assign bus.ctrl_extra_cycles = extra_cycles;
   assign bus.busy              = (state != IDLE);
   assign bus.dbg_state         = state;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Grant selection, command acceptance and next-state decode.
   always_comb begin
      state_n    = state;
      grant      = 1'b0;
      take       = 1'b0;
      accept     = 1'b0;
      rd_hit     = 1'b0;
      rd_timeout = 1'b0;
      if (bus.p0_req_valid && bus.p1_req_valid) grant = ~last_grant;
      else                                      grant = bus.p1_req_valid;
      case (state)
         IDLE: begin
            if (bus.p0_req_valid || bus.p1_req_valid) begin
               take    = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            // The enable is high for the whole of ISSUE, so a matching
            // main_state on any ISSUE cycle means the command was consumed.
            if (lat_write) accept = (bus.ctrl_main_state == STATE_W'(STATE_WRITE_DATA));
            else           accept = (bus.ctrl_main_state == STATE_W'(STATE_READ_DATA));
            if (accept) state_n = lat_write ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            // Data arriving on the timeout cycle still counts as data.
            if (bus.ctrl_rdata_valid) begin
               rd_hit  = 1'b1;
               state_n = RESP;
            end else if (timer == TMR_W'(READ_TIMEOUT)) begin
               rd_timeout = 1'b1;
               state_n    = RESP;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outstanding demand seen by the controller, clamped to its postpone limit.
   always_comb begin
      demand = {2'b00, bus.p0_req_valid} + {2'b00, bus.p1_req_valid} + {2'b00, (state != IDLE)};
      if (32'(demand) > MAX_POSTPONE) extra_n = EC_W'(MAX_POSTPONE);
      else                            extra_n = EC_W'(demand);
   end

   // Latched command, controller strobes, read timer and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant   <= 1'b1;
         lat_write    <= 1'b0;
         lat_port     <= 1'b0;
         timer        <= '0;
         write_enable <= 1'b0;
         read_enable  <= 1'b0;
         address      <= '0;
         wdata        <= '0;
         rsp_valid    <= 1'b0;
         rsp_port     <= 1'b0;
         rsp_rdata    <= '0;
         rsp_error    <= 1'b0;
         extra_cycles <= '0;
      end else begin
         rsp_valid    <= 1'b0;
         extra_cycles <= extra_n;
         case (state)
            IDLE: begin
               if (take) begin
                  lat_write    <= sel_write;
                  lat_port     <= grant;
                  last_grant   <= grant;
                  address      <= sel_addr;
                  wdata        <= sel_wdata;
                  write_enable <= sel_write;
                  read_enable  <= ~sel_write;
               end
            end
            ISSUE: begin
               if (accept) begin
                  write_enable <= 1'b0;
                  read_enable  <= 1'b0;
                  timer        <= '0;
               end
            end
            RDWAIT: begin
               timer <= timer + 1'b1;
               if (rd_hit) begin
                  rsp_valid <= 1'b1;
                  rsp_port  <= lat_port;
                  rsp_rdata <= bus.ctrl_rdata;
                  rsp_error <= 1'b0;
               end else if (rd_timeout) begin
                  rsp_valid <= 1'b1;
                  rsp_port  <= lat_port;
                  rsp_rdata <= '0;
                  rsp_error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Directed bench for ddr3_user_port_arbiter: a table of single transactions
// followed by hand-written timeout, data-on-timeout, reset and contention runs.
module tb_ddr3_user_port_arbiter;
   localparam int ADDR_W = 17;
   localparam int DQ_W   = 16;
   localparam logic [4:0] ST_WR = 5'd8;
   localparam logic [4:0] ST_RD = 5'd11;

   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   int   rsp_cnt;

   ddr3_user_port_arbiter_if #(.ADDR_W(ADDR_W), .DQ_W(DQ_W), .STATE_W(5), .MAX_POSTPONE(8)) bus ();

   ddr3_user_port_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic              port;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DQ_W-1:0]   wdata;
      int                acc;      // ISSUE cycle on which main_state matches
      logic              decoy;    // drive the other command's state before that
      int                rd_dly;   // RDWAIT cycle carrying rdata_valid
      logic [DQ_W-1:0]   rdata;
      int                exp_en;
      int                exp_rsp;
      logic              exp_port;
      logic [DQ_W-1:0]   exp_rdata;
      logic              exp_err;
   } vec_t;

   vec_t vecs[5];

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts response pulses, one per cycle high.
   always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive_req(input logic port, input logic valid, input logic write,
                            input logic [ADDR_W-1:0] addr, input logic [DQ_W-1:0] wdata);
      if (port == 1'b0) begin
         bus.p0_req_valid = valid; bus.p0_req_write = write;
         bus.p0_req_addr  = addr;  bus.p0_req_wdata = wdata;
      end else begin
         bus.p1_req_valid = valid; bus.p1_req_write = write;
         bus.p1_req_addr  = addr;  bus.p1_req_wdata = wdata;
      end
   endtask

   // Presents a request, checks it is granted, and leaves us in the first ISSUE cycle.
   task automatic start_txn(input logic port, input logic write,
                            input logic [ADDR_W-1:0] addr, input logic [DQ_W-1:0] wdata);
      @(negedge clk);
      drive_req(port, 1'b1, write, addr, wdata);
      #1;
      check("ready_granted", 32'(port ? bus.p1_req_ready : bus.p0_req_ready), 32'd1);
      check("ready_other",   32'(port ? bus.p0_req_ready : bus.p1_req_ready), 32'd0);
      @(negedge clk);
      drive_req(port, 1'b0, write, addr, wdata);
   endtask

   // Plays the controller through ISSUE; returns cycles the enable was seen high.
   task automatic issue_phase(input logic write, input logic [ADDR_W-1:0] addr,
                              input logic [DQ_W-1:0] wdata, input int acc,
                              input logic decoy, output int en_cnt);
      en_cnt = 0;
      for (int c = 1; c <= acc; c++) begin
         if (bus.ctrl_write_enable === write && bus.ctrl_read_enable === ~write) en_cnt++;
         check("issue_addr", 32'(bus.ctrl_address), 32'(addr));
         if (write) check("issue_wdata", 32'(bus.ctrl_wdata), 32'(wdata));
         if (c == acc)  bus.ctrl_main_state = write ? ST_WR : ST_RD;
         else if (decoy) bus.ctrl_main_state = write ? ST_RD : ST_WR;
         else            bus.ctrl_main_state = 5'd0;
         @(negedge clk);
      end
      bus.ctrl_main_state = 5'd0;
      check("enables_drop", 32'({bus.ctrl_write_enable, bus.ctrl_read_enable}), 32'd0);
   endtask

   // Waits in RDWAIT for the response; optionally injects data on cycle inj.
   task automatic wait_rsp(input int inj, input logic [DQ_W-1:0] data, output int n);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 2000) begin
         if (n == inj) begin
            bus.ctrl_rdata_valid = 1'b1;
            bus.ctrl_rdata       = data;
         end
         @(negedge clk);
         bus.ctrl_rdata_valid = 1'b0;
         n++;
      end
   endtask

   initial begin
      int en_cnt;
      int base;
      int n;

      n_total = 0; n_pass = 0; rsp_cnt = 0;
      reset = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, 1'b0, '0, '0);
      bus.ctrl_main_state  = 5'd0;
      bus.ctrl_rdata       = '0;
      bus.ctrl_rdata_valid = 1'b0;

      //                port  wr    addr       wdata    acc dec rd  rdata    en rsp port rdata  err
      vecs[0] = '{1'b0, 1'b1, 17'h00005, 16'hA5A5, 3, 1'b1, 0, 16'h0000, 3, 0, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 17'h00002, 16'h0000, 2, 1'b0, 4, 16'h1234, 2, 1, 1'b1, 16'h1234, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, 1, 1'b0, 1, 16'hBEEF, 1, 1, 1'b0, 16'hBEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 17'h1FFFF, 16'hFFFF, 1, 1'b0, 0, 16'h0000, 1, 0, 1'b0, 16'h0000, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 17'h0ABCD, 16'h0000, 5, 1'b1, 2, 16'h0F0F, 5, 1, 1'b0, 16'h0F0F, 1'b0};

      repeat (3) @(negedge clk);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_en",    32'({bus.ctrl_write_enable, bus.ctrl_read_enable}), 32'd0);
      check("rst_rsp",   32'({bus.rsp_valid, bus.rsp_port, bus.rsp_error}), 32'd0);
      check("rst_addr",  32'(bus.ctrl_address), 32'd0);
      check("rst_extra", 32'(bus.ctrl_extra_cycles), 32'd0);
      reset = 1'b0;

      // Table of single, uncontended transactions.
      for (int i = 0; i < 5; i++) begin
         base = rsp_cnt;
         start_txn(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata);
         issue_phase(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].acc, vecs[i].decoy, en_cnt);
         check("en_cycles", 32'(en_cnt), 32'(vecs[i].exp_en));
         if (!vecs[i].write) begin
            for (int c = 1; c <= vecs[i].rd_dly; c++) begin
               if (c == vecs[i].rd_dly) begin
                  bus.ctrl_rdata_valid = 1'b1;
                  bus.ctrl_rdata       = vecs[i].rdata;
               end
               @(negedge clk);
            end
            bus.ctrl_rdata_valid = 1'b0;
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rsp_port",  32'(bus.rsp_port),  32'(vecs[i].exp_port));
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(vecs[i].exp_rdata));
            check("rsp_error", 32'(bus.rsp_error), 32'(vecs[i].exp_err));
            @(negedge clk);
         end
         check("busy_after", 32'(bus.busy), 32'd0);
         @(negedge clk);
         check("rsp_count", 32'(rsp_cnt - base), 32'(vecs[i].exp_rsp));
      end

      // Read that never gets data: error response 1024 cycles into RDWAIT.
      start_txn(1'b0, 1'b0, 17'h00077, 16'h0000);
      issue_phase(1'b0, 17'h00077, 16'h0000, 1, 1'b0, en_cnt);
      wait_rsp(-1, 16'h0000, n);
      check("timeout_cycles", 32'(n), 32'd1024);
      check("timeout_error",  32'(bus.rsp_error), 32'd1);
      check("timeout_rdata",  32'(bus.rsp_rdata), 32'd0);
      check("timeout_port",   32'(bus.rsp_port),  32'd0);
      @(negedge clk);

      // Data arriving on the very cycle the timer expires wins.
      start_txn(1'b1, 1'b0, 17'h00123, 16'h0000);
      issue_phase(1'b0, 17'h00123, 16'h0000, 1, 1'b0, en_cnt);
      wait_rsp(1023, 16'h7E57, n);
      check("edge_cycles", 32'(n), 32'd1024);
      check("edge_error",  32'(bus.rsp_error), 32'd0);
      check("edge_rdata",  32'(bus.rsp_rdata), 32'h7E57);
      check("edge_port",   32'(bus.rsp_port),  32'd1);
      @(negedge clk);

      // Reset while waiting for read data: the read is dropped silently.
      start_txn(1'b1, 1'b0, 17'h1ABCD, 16'h3C3C);
      issue_phase(1'b0, 17'h1ABCD, 16'h3C3C, 1, 1'b0, en_cnt);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy",  32'(bus.busy), 32'd0);
      check("mid_rst_en",    32'({bus.ctrl_write_enable, bus.ctrl_read_enable}), 32'd0);
      check("mid_rst_rsp",   32'({bus.rsp_valid, bus.rsp_port, bus.rsp_error}), 32'd0);
      check("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("mid_rst_addr",  32'(bus.ctrl_address), 32'd0);
      check("mid_rst_wdata", 32'(bus.ctrl_wdata), 32'd0);
      check("mid_rst_extra", 32'(bus.ctrl_extra_cycles), 32'd0);
      reset = 1'b0;
      base = rsp_cnt;
      bus.ctrl_rdata_valid = 1'b1;
      bus.ctrl_rdata       = 16'h5555;
      @(negedge clk);
      bus.ctrl_rdata_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("stale_data_rsp", 32'(rsp_cnt - base), 32'd0);

      // Both ports hold write requests; grants alternate starting with port 0.
      bus.ctrl_main_state = ST_WR;
      drive_req(1'b0, 1'b1, 1'b1, 17'h00AAA, 16'h1111);
      drive_req(1'b1, 1'b1, 1'b1, 17'h15555, 16'h2222);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_ready0", 32'(bus.p0_req_ready), 32'((i % 2) == 0));
         check("cont_ready1", 32'(bus.p1_req_ready), 32'((i % 2) == 1));
         if (i > 0) check("cont_extra_idle", 32'(bus.ctrl_extra_cycles), 32'd3);
         @(negedge clk);
         check("cont_we",    32'(bus.ctrl_write_enable), 32'd1);
         check("cont_addr",  32'(bus.ctrl_address), (i % 2) == 0 ? 32'h00AAA : 32'h15555);
         check("cont_wdata", 32'(bus.ctrl_wdata),   (i % 2) == 0 ? 32'h1111  : 32'h2222);
         check("cont_extra_issue", 32'(bus.ctrl_extra_cycles), 32'd2);
         if (i == 3) begin
            drive_req(1'b0, 1'b0, 1'b1, 17'h00AAA, 16'h1111);
            drive_req(1'b1, 1'b0, 1'b1, 17'h15555, 16'h2222);
         end
         @(negedge clk);
      end
      check("cont_end_busy",  32'(bus.busy), 32'd0);
      check("cont_end_we",    32'(bus.ctrl_write_enable), 32'd0);
      check("cont_end_extra", 32'(bus.ctrl_extra_cycles), 32'd1);
      @(negedge clk);
      check("cont_idle_extra", 32'(bus.ctrl_extra_cycles), 32'd0);
      bus.ctrl_main_state = 5'd0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/ddr3_user_port_arbiter.md
Name: ddr3_user_port_arbiter

Overview:
- Shares the single user port of ddr3_memory_controller between two requesters: a loopback/test engine and a host-side client.
- Round-robin arbitration; one transaction outstanding at a time.
- Holds write_enable/read_enable with address/data stable until the controller's main_state shows the command was consumed, then returns read data with port tag and timeout error.
- Drives user_desired_extra_read_or_write_cycles from pending demand.

Parameters:
ADDR_W, 17, user address width (bank + row/col bits, 3+14).
DQ_W, 16, data width.
STATE_W, 5, controller main_state width.
STATE_WRITE_DATA, 8, main_state value meaning the write was accepted.
STATE_READ_DATA, 11, main_state value meaning the read was accepted.
MAX_POSTPONE, 8, clamp for the extra-cycles output.
READ_TIMEOUT, 1023, RDWAIT cycles before the error response.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
p0_req_valid  in  1  port 0 request
p0_req_ready  out  1  port 0 accept (combinational)
p0_req_write  in  1  1=write, 0=read
p0_req_addr  in  ADDR_W  address
p0_req_wdata  in  DQ_W  write data
p1_req_valid / p1_req_ready / p1_req_write / p1_req_addr / p1_req_wdata  same as port 0
rsp_valid  out  1  one-cycle read response pulse
rsp_port  out  1  port id of the response
rsp_rdata  out  DQ_W  read data (0 on error)
rsp_error  out  1  read timed out
ctrl_write_enable  out  1  to controller write_enable
ctrl_read_enable  out  1  to controller read_enable
ctrl_address  out  ADDR_W  to i_user_data_address
ctrl_wdata  out  DQ_W  to data_to_ram
ctrl_main_state  in  STATE_W  from controller main_state
ctrl_rdata  in  DQ_W  from data_from_ram
ctrl_rdata_valid  in  1  data_from_ram valid strobe
ctrl_extra_cycles  out  clog2(MAX_POSTPONE)+1  to user_desired_extra_read_or_write_cycles
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, last_grant=1 (so port 0 wins first), and every output is 0. Reset mid-transaction drops the outstanding request with no response; ctrl enables go low the next cycle.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE, grant selection:
  - Only one port valid: grant it.
  - Both ports valid: grant the port != last_grant.
  - pN_req_ready = (state==IDLE) & grant==N, combinational. A ready is never asserted without its valid.
- IDLE, on handshake:
  - Latch write/addr/wdata/port.
  - last_grant <= port.
  - Next state ISSUE.
- ISSUE:
  - Register ctrl_write_enable or ctrl_read_enable = latched write flag (exactly one high). ctrl_address/ctrl_wdata equal the latched values, stable throughout.
  - Acceptance: the first cycle where ctrl_main_state==STATE_WRITE_DATA (write) or STATE_READ_DATA (read) while the enable is high. The enable is high from the first ISSUE cycle, so a matching state on that cycle counts.
  - Write accepted: -> IDLE; enable deasserted next cycle; no response.
  - Read accepted: -> RDWAIT; timer <= 0.
  - No timeout in ISSUE (the controller may be refreshing).
- ctrl_wdata holds its last value when idle. ctrl_address holds too.
- RDWAIT:
  - ctrl_read_enable = 0; timer increments each cycle.
  - ctrl_rdata_valid: capture ctrl_rdata, -> RESP, error=0.
  - Else if timer==READ_TIMEOUT: -> RESP, rdata=0, error=1.
  - Valid and timeout on the same cycle: data wins.
  - ctrl_rdata_valid outside RDWAIT is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle, no backpressure; rsp_port/rsp_rdata/rsp_error are valid that cycle.
  - -> IDLE. A new grant is possible the following cycle.
- ctrl_extra_cycles: registered, = min(p0_req_valid + p1_req_valid + (state!=IDLE), MAX_POSTPONE).
- Latency, read request handshake (cycle 0), controller reaches STATE_READ_DATA at cycle k≥1, rdata_valid at cycle m>k: rsp_valid at cycle m+1.

Test Plan:
- Single write: p0 write addr 0x00005, data 0xA5A5; main_state=8 on 3rd ISSUE cycle -> ctrl_write_enable high exactly 3 cycles, address/data stable, no rsp_valid, busy low after.
- Single read: p1 read addr 0x00002; main_state=11 after 2 cycles, rdata_valid with 0x1234 4 cycles later -> one rsp_valid, rsp_port=1, rsp_rdata=0x1234, rsp_error=0.
- Contention: both ports hold valid for 4 back-to-back writes, each accepted immediately -> grants 0,1,0,1; ctrl_extra_cycles=3 while both are pending and busy.
- Timeout: read accepted, rdata_valid never arrives -> rsp_valid exactly 1024 cycles after entering RDWAIT, rsp_error=1, rsp_rdata=0.
- Reset mid-RDWAIT: assert reset for 1 cycle -> all outputs 0; a later rdata_valid produces no rsp_valid; the next request arbitrates port 0 first.
- Boundary: rdata_valid and timeout on the same cycle -> rsp_error=0 with data. Address 0x1FFFF passes unchanged to ctrl_address.
